// File: rtl/button_conditioner.sv
// button_conditioner: input front end of the stopwatch.
// Raw board inputs (pause/reset buttons, select/adjust switches) are
// synchronized, debounced, and the button channels are reduced to press
// events: a pause toggle and a single-cycle stopwatch-reset pulse.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_pause,
   input  logic btn_rst,
   input  logic sw_sel,
   input  logic sw_adj,
   output logic paused,
   output logic rst_pulse,
   output logic sel,
   output logic adj
);

   localparam int NUM_CH   = 4;
   localparam int CH_PAUSE = 0;
   localparam int CH_RST   = 1;
   localparam int CH_SEL   = 2;
   localparam int CH_ADJ   = 3;
   localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_CH-1:0] raw;
   logic [NUM_CH-1:0] sync1;
   logic [NUM_CH-1:0] sync2;
   logic [NUM_CH-1:0] db;
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [1:0]        db_q;
   logic [1:0]        press;

   assign raw = {sw_adj, sw_sel, btn_rst, btn_pause};

   // Two-flop synchronizer for every raw input.
   // NOTE: sequential state uses non-blocking assignments so sync2 picks up
   // the old sync1 value; blocking here would collapse the chain to one flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Per-channel debouncer: accept a new level after DEBOUNCE_CYCLES
   // consecutive cycles of disagreement; any agreeing cycle restarts the count.
   // NOTE: the counters are ordinary flops and are cleared by reset, so a
   // transition half-counted when rst arrives is discarded rather than resumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Edge history for the two button channels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_q <= '0;
      end else begin
         db_q <= db[CH_RST:CH_PAUSE];
      end
   end

   // A press is a debounced rising edge; releases are ignored.
   assign press = db[CH_RST:CH_PAUSE] & ~db_q;

   // Registered button events: pause toggle and one-cycle reset pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         paused    <= 1'b0;
         rst_pulse <= 1'b0;
      end else begin
         paused    <= paused ^ press[CH_PAUSE];
         rst_pulse <= press[CH_RST];
      end
   end

   assign sel = db[CH_SEL];
   assign adj = db[CH_ADJ];

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and randomized checks of button_conditioner
// with DEBOUNCE_CYCLES = 4 against a window-based reference model.
module tb_button_conditioner;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   logic btn_pause, btn_rst, sw_sel, sw_adj;
   logic paused, rst_pulse, sel, adj;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   // Reference model: raw samples pass through a 2-deep delay line; a channel's
   // debounced level flips once the last N synchronized samples all disagree
   // with it. Button rises become events one edge later.
   logic [3:0] raw_q [$];
   logic [3:0] s_win [$];
   logic [3:0] d_m;
   logic [1:0] rose_prev;
   logic       paused_m;
   logic       pulse_m;

   button_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_pause (btn_pause),
      .btn_rst   (btn_rst),
      .sw_sel    (sw_sel),
      .sw_adj    (sw_adj),
      .paused    (paused),
      .rst_pulse (rst_pulse),
      .sel       (sel),
      .adj       (adj)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      raw_q.delete();
      raw_q.push_back(4'b0);
      raw_q.push_back(4'b0);
      s_win.delete();
      d_m       = '0;
      rose_prev = '0;
      paused_m  = 1'b0;
      pulse_m   = 1'b0;
   endtask

   task automatic model_edge();
      logic [3:0] raw_now;
      logic [3:0] s_now;
      logic [3:0] rose_now;
      bit         all_diff;
      raw_now = {sw_adj, sw_sel, btn_rst, btn_pause};
      s_now   = raw_q.pop_front();
      raw_q.push_back(raw_now);
      paused_m = paused_m ^ rose_prev[0];
      pulse_m  = rose_prev[1];
      s_win.push_back(s_now);
      if (s_win.size() > N) void'(s_win.pop_front());
      rose_now = '0;
      if (s_win.size() == N) begin
         for (int c = 0; c < 4; c++) begin
            all_diff = 1'b1;
            foreach (s_win[i]) if (s_win[i][c] == d_m[c]) all_diff = 1'b0;
            if (all_diff) begin
               d_m[c]      = ~d_m[c];
               rose_now[c] = d_m[c];
            end
         end
      end
      rose_prev = rose_now[1:0];
   endtask

   // One clock edge: advance the model, then compare all outputs after the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("paused",    paused,    paused_m);
      check("rst_pulse", rst_pulse, pulse_m);
      check("sel",       sel,       d_m[2]);
      check("adj",       adj,       d_m[3]);
   endtask

   // Asynchronous reset between edges; outputs must clear before any edge.
   task automatic reset_dut();
      #2 rst = 1'b1;
      #1;
      check("rst_paused",    paused,    1'b0);
      check("rst_rst_pulse", rst_pulse, 1'b0);
      check("rst_sel",       sel,       1'b0);
      check("rst_adj",       adj,       1'b0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   initial begin
      int first_edge, second_edge, toggles, pulses;
      logic last_p;

      rst = 1'b1;
      btn_pause = 1'b0; btn_rst = 1'b0; sw_sel = 1'b0; sw_adj = 1'b0;
      model_reset();
      #1;
      check("init_paused",    paused,    1'b0);
      check("init_rst_pulse", rst_pulse, 1'b0);
      check("init_sel",       sel,       1'b0);
      check("init_adj",       adj,       1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      repeat (3) step();

      // Clean btn_rst press held: pulse only after edge 7.
      btn_rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         check("t2_pulse_timing", rst_pulse, (k == 7));
      end
      btn_rst = 1'b0;
      repeat (10) step();

      // Bouncing pause press: exactly one toggle, at edge 11.
      first_edge = -1; toggles = 0; last_p = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         btn_pause = (k <= 4) ? logic'(k % 2) : 1'b1;
         step();
         if (paused !== last_p) begin
            toggles++;
            if (first_edge < 0) first_edge = k;
         end
         last_p = paused;
      end
      check("t3_toggle_count", toggles, 1);
      check("t3_toggle_edge", first_edge, 11);
      btn_pause = 1'b0;
      repeat (10) step();

      // Two press/release cycles: toggles on presses only.
      btn_pause = 1'b1; repeat (10) step(); check("t4_press1",   paused, 1'b0);
      btn_pause = 1'b0; repeat (10) step(); check("t4_release1", paused, 1'b0);
      btn_pause = 1'b1; repeat (10) step(); check("t4_press2",   paused, 1'b1);
      btn_pause = 1'b0; repeat (10) step(); check("t4_release2", paused, 1'b1);

      // Simultaneous pause and rst press: both take effect on the same edge.
      first_edge = -1; second_edge = -1;
      btn_pause = 1'b1; btn_rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (rst_pulse === 1'b1 && first_edge < 0) first_edge = k;
         if (paused === 1'b0 && second_edge < 0) second_edge = k;
      end
      check("t5_pulse_edge", first_edge, 7);
      check("t5_toggle_edge", second_edge, 7);
      btn_pause = 1'b0; btn_rst = 1'b0;
      repeat (10) step();

      // Select switch glitch of N-1 synchronized cycles is rejected.
      first_edge = -1;
      for (int k = 1; k <= 16; k++) begin
         sw_sel = (k <= 3) ? 1'b1 : ((k <= 6) ? 1'b0 : 1'b1);
         step();
         if (sel === 1'b1 && first_edge < 0) first_edge = k;
      end
      check("t6_sel_rise_edge", first_edge, 12);

      // Reset mid-run with paused set and counts in flight.
      btn_pause = 1'b1; repeat (10) step();
      btn_pause = 1'b0; repeat (10) step();
      check("t1_paused_before", paused, 1'b1);
      sw_adj = 1'b1; btn_rst = 1'b1;
      repeat (3) step();
      reset_dut();
      btn_rst = 1'b0; sw_adj = 1'b0;
      pulses = 0;
      repeat (12) begin
         step();
         if (rst_pulse === 1'b1) pulses++;
      end
      check("t1_no_pulse_after", pulses, 0);
      check("t1_paused_after", paused, 1'b0);

      // Button held through reset is re-qualified and yields one press.
      btn_rst = 1'b1;
      repeat (3) step();
      reset_dut();
      pulses = 0;
      repeat (12) begin
         step();
         if (rst_pulse === 1'b1) pulses++;
      end
      check("t7_requalified_pulses", pulses, 1);
      btn_rst = 1'b0;
      repeat (8) step();

      // Randomized input segments against the model.
      for (int seg = 0; seg < 60; seg++) begin
         logic [3:0] v;
         v = 4'($urandom);
         {sw_adj, sw_sel, btn_rst, btn_pause} = v;
         repeat ($urandom_range(1, 7)) step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
